// File: rtl/wallace_mult_arbiter.sv
// Two-client arbiter sharing one combinational 8x8 Wallace-tree multiplier.
// Define WALLACE_ARB_RR_EN for round-robin arbitration; default is fixed priority to client 0.

module wallace_eight_bit_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [16:0] out
);
  logic [16:0] pp [8];
  logic [16:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pp
    assign pp[gi] = b[gi] ? ({9'd0, a} << gi) : 17'd0;
  end

  // 3:2 compressor on whole words; carries beyond bit 16 never matter since the product fits.
  function automatic logic [33:0] csa(input logic [16:0] x, input logic [16:0] y,
                                      input logic [16:0] z);
    logic [16:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[15:0], 1'b0, x ^ y ^ z};
  endfunction

  assign {c1, s1} = csa(pp[0], pp[1], pp[2]);
  assign {c2, s2} = csa(pp[3], pp[4], pp[5]);
  assign {c3, s3} = csa(s1, c1, s2);
  assign {c4, s4} = csa(c2, pp[6], pp[7]);
  assign {c5, s5} = csa(s3, c3, s4);
  assign {c6, s6} = csa(s5, c5, c4);
  assign out = s6 + c6;
endmodule

module wallace_mult_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [16:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [16:0] rsp1_data,
  output logic        busy,
  output logic [15:0] op_count
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  opa_q, opa_d, opb_q, opb_d;
  logic [16:0] res_q, res_d;
  logic        owner_q, owner_d;
  logic [15:0] op_count_q, op_count_d;
  logic [16:0] prod;
  logic        ptr;
  logic        grant;
  logic        rsp_hs;

  wallace_eight_bit_multiplier u_mult (
    .a  (opa_q),
    .b  (opb_q),
    .out(prod)
  );

  assign rsp_hs = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

`ifdef WALLACE_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (rsp_hs) ptr_d = ~owner_q;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  // With both clients valid the pointer decides; fixed priority ties it to 0.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ptr;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      opa_q      <= 8'd0;
      opb_q      <= 8'd0;
      res_q      <= 17'd0;
      owner_q    <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      res_q      <= res_d;
      owner_q    <= owner_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_d      = res_q;
    owner_d    = owner_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          opa_d   = grant ? req1_a : req0_a;
          opb_d   = grant ? req1_b : req0_b;
          owner_d = grant;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = prod;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) && owner_q;
  assign rsp0_data  = rsp0_valid ? res_q : 17'd0;
  assign rsp1_data  = rsp1_valid ? res_q : 17'd0;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;
endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Self-checking bench for wallace_mult_arbiter: transaction-level model of products,
// response count and arbitration pointer, with randomized operands and backpressure.

module tb_wallace_mult_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [16:0] rsp0_data, rsp1_data;
  logic        busy;
  logic [15:0] op_count;

  int          total = 0;
  int          bad = 0;
  logic [15:0] cnt_m;
  int          ptr_m;

`ifdef WALLACE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  wallace_mult_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp0_data (rsp0_data),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp1_data (rsp1_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    cnt_m = 16'd0; ptr_m = 0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got busy/v0/v1/r0/r1=%b need 00000",
               {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
    end
    total++;
    if (rsp0_data !== 17'd0 || rsp1_data !== 17'd0 || op_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_data got d0=%h d1=%h cnt=%h need 0 0 0", rsp0_data, rsp1_data, op_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One complete transaction for client c; stall = cycles of response backpressure.
  task automatic do_op(input int c, input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [16:0] exp;
    logic        mv, ov, mr, orr;
    logic [16:0] md, od;
    exp = 17'(a) * 17'(b);
    if (c == 0) begin
      req0_a = a; req0_b = b; req0_valid = 1; rsp0_ready = (stall == 0);
    end else begin
      req1_a = a; req1_b = b; req1_valid = 1; rsp1_ready = (stall == 0);
    end
    #1;
    mr = c ? req1_ready : req0_ready;
    orr = c ? req0_ready : req1_ready;
    total++;
    if (mr !== 1'b1 || orr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL accept c=%0d got ready=%b other=%b busy=%b need 1 0 0", c, mr, orr, busy);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    total++;
    if (busy !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      bad++;
      $display("FAIL calc c=%0d got busy=%b v0=%b v1=%b need 1 0 0", c, busy, rsp0_valid, rsp1_valid);
    end
    @(negedge clk);
    #1;
    mv = c ? rsp1_valid : rsp0_valid; md = c ? rsp1_data : rsp0_data;
    ov = c ? rsp0_valid : rsp1_valid; od = c ? rsp0_data : rsp1_data;
    total++;
    if (mv !== 1'b1 || md !== exp || ov !== 1'b0 || od !== 17'd0) begin
      bad++;
      $display("FAIL resp c=%0d a=%0d b=%0d got v=%b d=%0d ov=%b od=%0d need 1 %0d 0 0",
               c, a, b, mv, md, ov, od, exp);
    end
    for (int i = 0; i < stall; i++) begin
      if (c == 0) begin req1_valid = 1; req1_a = 8'($urandom); req1_b = 8'($urandom); end
      else        begin req0_valid = 1; req0_a = 8'($urandom); req0_b = 8'($urandom); end
      #1;
      mv = c ? rsp1_valid : rsp0_valid; md = c ? rsp1_data : rsp0_data;
      orr = c ? req0_ready : req1_ready;
      total++;
      if (mv !== 1'b1 || md !== exp || busy !== 1'b1 || orr !== 1'b0) begin
        bad++;
        $display("FAIL stall c=%0d cyc=%0d got v=%b d=%0d busy=%b oready=%b need 1 %0d 1 0",
                 c, i, mv, md, busy, orr, exp);
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    if (c == 0) rsp0_ready = 1; else rsp1_ready = 1;
    @(negedge clk);
    #1;
    cnt_m = cnt_m + 16'd1;
    ptr_m = RR ? 1 - c : 0;
    total++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 || op_count !== cnt_m) begin
      bad++;
      $display("FAIL done c=%0d got v0=%b v1=%b busy=%b cnt=%h need 0 0 0 %h",
               c, rsp0_valid, rsp1_valid, busy, op_count, cnt_m);
    end
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_single();
    do_op(0, 8'd255, 8'd255, 0);
  endtask

  task automatic test_contention();
    logic [16:0] exp, gd;
    int          g;
    req0_a = 8'd3; req0_b = 8'd5; req1_a = 8'd7; req1_b = 8'd9;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      g = ptr_m;
      exp = (g == 0) ? 17'd15 : 17'd63;
      #1;
      total++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        bad++;
        $display("FAIL contend_grant k=%0d got r0=%b r1=%b need grant %0d", k, req0_ready, req1_ready, g);
      end
      @(negedge clk); @(negedge clk);
      #1;
      gd = g ? rsp1_data : rsp0_data;
      total++;
      if (rsp0_valid !== (g == 0) || rsp1_valid !== (g == 1) || gd !== exp) begin
        bad++;
        $display("FAIL contend_rsp k=%0d got v0=%b v1=%b d=%0d need owner %0d d=%0d",
                 k, rsp0_valid, rsp1_valid, gd, g, exp);
      end
      @(negedge clk);
      cnt_m = cnt_m + 16'd1;
      ptr_m = RR ? 1 - g : 0;
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    #1;
    total++;
    if (op_count !== cnt_m) begin
      bad++;
      $display("FAIL contend_count got %h need %h", op_count, cnt_m);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_op(1, 8'd200, 8'd100, 5);
  endtask

  task automatic test_back_to_back();
    do_op(0, 8'd0, 8'd173, 0);
    do_op(1, 8'd1, 8'd255, 0);
    do_op(0, 8'd128, 8'd2, 0);
  endtask

  task automatic test_reset_mid();
    req0_a = 8'd12; req0_b = 8'd13; req0_valid = 1; rsp0_ready = 0;
    @(negedge clk);
    req0_valid = 0;
    rst = 1'b1;
    #1;
    cnt_m = 16'd0; ptr_m = 0;
    total++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp0_data !== 17'd0 || op_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_calc got busy=%b v0=%b d0=%0d cnt=%h need 0 0 0 0", busy, rsp0_valid, rsp0_data, op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp0_data !== 17'd0 || op_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_resp got busy=%b v0=%b d0=%0d cnt=%h need 0 0 0 0", busy, rsp0_valid, rsp0_data, op_count);
    end
    rsp0_ready = 1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (rsp0_valid !== 1'b0 || op_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_nodeliver got v0=%b cnt=%h need 0 0", rsp0_valid, op_count);
    end
    rsp0_ready = 0;
    do_op(0, 8'd21, 8'd11, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++)
      do_op(int'($urandom_range(1, 0)), 8'($urandom), 8'($urandom), int'($urandom_range(3, 0)));
  endtask

  task automatic test_wrap();
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    cnt_m = 16'hFFFE;
    total++;
    if (op_count !== 16'hFFFE) begin
      bad++;
      $display("FAIL wrap_preload got %h need fffe", op_count);
    end
    @(negedge clk);
    do_op(1, 8'($urandom), 8'($urandom), 0);
    do_op(0, 8'($urandom), 8'($urandom), 2);
    total++;
    if (op_count !== 16'h0001 || cnt_m !== 16'h0000) begin
      if (op_count !== 16'h0000) begin
        bad++;
        $display("FAIL wrap_zero got %h need 0000", op_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
